icg_enable_ctrl: RTL and testbench



---
 rtl/icg_enable_ctrl_pkg.sv | 29 ++
 rtl/icg_ctrl_downcnt.sv | 35 +++
 rtl/icg_enable_ctrl.sv | 118 +++++++++++
 tb/tb_icg_enable_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/icg_enable_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icg_enable_ctrl_pkg
// Description : State encoding and helpers shared by the icgtn enable
//               controller and its down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package icg_enable_ctrl_pkg;

    // Controller state, also exported on the STATE status port
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } icg_state_e;

    localparam logic [1:0] c_st_off   = ST_OFF;
    localparam logic [1:0] c_st_wake  = ST_WAKE;
    localparam logic [1:0] c_st_on    = ST_ON;
    localparam logic [1:0] c_st_drain = ST_DRAIN;

    // Larger of two integers, used to size the shared wake/drain counter
    function automatic int icg_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icg_ctrl_downcnt.sv
`default_nettype none
// ============================================================================
// Module      : icg_ctrl_downcnt
// Description : Loadable down-counter with zero flag. Timing source for both
//               the wake period and the idle drain period.
// Revision    : 1.0 - initial release
// ============================================================================
module icg_ctrl_downcnt #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement; decrement stops at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/icg_enable_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icg_enable_ctrl
// Description : Enable controller for a negative-edge ICG (icgtn). Wakes the
//               gated domain on client activity, grants ACK once E has been
//               high for WAKE_CYCLES, and closes the gate after IDLE_CYCLES
//               of inactivity. TE is a direct passthrough of SCAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module icg_enable_ctrl
    import icg_enable_ctrl_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic [N_REQ-1:0] BUSY,
    input  logic             FORCE_ON,
    input  logic             SCAN_EN,
    output logic             E,
    output logic             TE,
    output logic [N_REQ-1:0] ACK,
    output logic [1:0]       STATE
);

    localparam int c_cnt_w = $clog2(icg_max(WAKE_CYCLES, IDLE_CYCLES) + 1);
    localparam logic [c_cnt_w-1:0] c_wake_load = c_cnt_w'(WAKE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_idle_load = c_cnt_w'(IDLE_CYCLES - 1);

    logic [1:0]         r_state;
    logic               r_e;
    logic [N_REQ-1:0]   r_ack;

    logic [1:0]         w_next_state;
    logic               w_active;
    logic               w_cnt_load;
    logic [c_cnt_w-1:0] w_cnt_load_val;
    logic               w_cnt_dec;
    logic               w_cnt_zero;

    assign w_active = (|REQ) | (|BUSY) | FORCE_ON;

    // Next-state and counter control; WAKE always runs to completion and
    // activity in DRAIN always wins over the timeout
    always_comb begin
        w_next_state   = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        case (r_state)
            c_st_off: begin
                if (w_active) begin
                    w_next_state   = c_st_wake;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_wake_load;
                end
            end
            c_st_wake: begin
                if (w_cnt_zero) begin
                    w_next_state = c_st_on;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            c_st_on: begin
                if (!w_active) begin
                    w_next_state   = c_st_drain;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_idle_load;
                end
            end
            c_st_drain: begin
                if (w_active) begin
                    w_next_state = c_st_on;
                end else if (w_cnt_zero) begin
                    w_next_state = c_st_off;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
        endcase
    end

    // State, E and ACK registers; E and ACK come from the next state so they
    // line up with STATE and E can only fall on the DRAIN->OFF edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_st_off;
            r_e     <= 1'b0;
            r_ack   <= '0;
        end else begin
            r_state <= w_next_state;
            r_e     <= (w_next_state != c_st_off);
            r_ack   <= REQ & {N_REQ{w_next_state == c_st_on}};
        end
    end

    icg_ctrl_downcnt #(
        .WIDTH (c_cnt_w)
    ) u_downcnt (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    assign E     = r_e;
    assign ACK   = r_ack;
    assign STATE = r_state;
    assign TE    = SCAN_EN;

endmodule
`default_nettype wire

// File: tb/tb_icg_enable_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icg_enable_ctrl
// Description : Self-checking bench for icg_enable_ctrl (defaults N_REQ=4,
//               WAKE_CYCLES=2, IDLE_CYCLES=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icg_enable_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] REQ = '0;
    logic [3:0] BUSY = '0;
    logic       FORCE_ON = 1'b0;
    logic       SCAN_EN = 1'b0;
    logic       E;
    logic       TE;
    logic [3:0] ACK;
    logic [1:0] STATE;

    int n_tests = 0;
    int n_fail  = 0;

    icg_enable_ctrl #(
        .N_REQ       (4),
        .WAKE_CYCLES (2),
        .IDLE_CYCLES (16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .BUSY     (BUSY),
        .FORCE_ON (FORCE_ON),
        .SCAN_EN  (SCAN_EN),
        .E        (E),
        .TE       (TE),
        .ACK      (ACK),
        .STATE    (STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] busy;
        logic       force_on;
        logic       scan_en;
        logic       exp_e;
        logic [3:0] exp_ack;
        logic [1:0] exp_state;
        logic       exp_te;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] bz,
                                input logic fo, input logic se, input logic ee,
                                input logic [3:0] ea, input logic [1:0] es);
        vec_t v;
        v.rst = r; v.req = rq; v.busy = bz; v.force_on = fo; v.scan_en = se;
        v.exp_e = ee; v.exp_ack = ea; v.exp_state = es; v.exp_te = se;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic ee, input logic [3:0] ea, input logic [1:0] es);
        check({name, ".E"},     {7'd0, E},     {7'd0, ee});
        check({name, ".ACK"},   {4'd0, ACK},   {4'd0, ea});
        check({name, ".STATE"}, {6'd0, STATE}, {6'd0, es});
    endtask

    // Drive inputs, take one rising edge, settle away from the edge
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] bz, input logic fo);
        RST = r; REQ = rq; BUSY = bz; FORCE_ON = fo;
        @(posedge CLK);
        #1;
    endtask

    // From OFF: wake with a request and reach ON with ACK=rq
    task automatic go_on(input string name, input logic [3:0] rq);
        cyc(1'b0, rq, 4'h0, 1'b0);
        chk3({name, ".wake1"}, 1'b1, 4'h0, 2'd1);
        cyc(1'b0, rq, 4'h0, 1'b0);
        chk3({name, ".wake2"}, 1'b1, 4'h0, 2'd1);
        cyc(1'b0, rq, 4'h0, 1'b0);
        chk3({name, ".on"}, 1'b1, rq, 2'd2);
    endtask

    initial begin
        //           rst  req    busy   fo   se   E    ACK    STATE
        vecs[0]  = mk(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 2'd0);
        vecs[1]  = mk(1, 4'h0, 4'h0, 0, 1, 0, 4'h0, 2'd0); // scan in reset
        vecs[2]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 2'd0);
        vecs[3]  = mk(0, 4'h0, 4'h0, 0, 1, 0, 4'h0, 2'd0); // scan in OFF
        vecs[4]  = mk(0, 4'h1, 4'h0, 0, 0, 1, 4'h0, 2'd1); // edge n: WAKE, E=1
        vecs[5]  = mk(0, 4'h1, 4'h0, 0, 0, 1, 4'h0, 2'd1);
        vecs[6]  = mk(0, 4'h1, 4'h0, 0, 0, 1, 4'h1, 2'd2); // n+2: ON + ACK
        vecs[7]  = mk(0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 2'd3); // REQ drop: ACK 0, DRAIN
        vecs[8]  = mk(0, 4'h2, 4'h0, 0, 0, 1, 4'h2, 2'd2); // back to ON, no re-wake
        vecs[9]  = mk(0, 4'h6, 4'h0, 0, 0, 1, 4'h6, 2'd2); // request while ON: 1 cycle
        vecs[10] = mk(0, 4'h0, 4'h8, 0, 0, 1, 4'h0, 2'd2); // BUSY holds ON
        vecs[11] = mk(0, 4'h0, 4'h0, 1, 0, 1, 4'h0, 2'd2); // FORCE_ON holds ON
        vecs[12] = mk(0, 4'h4, 4'h0, 1, 0, 1, 4'h4, 2'd2);
        vecs[13] = mk(0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 2'd3);
        vecs[14] = mk(0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 2'd3);
        vecs[15] = mk(1, 4'h0, 4'h0, 0, 1, 0, 4'h0, 2'd0); // reset from DRAIN

        for (int i = 0; i < 16; i++) begin
            SCAN_EN = vecs[i].scan_en;
            cyc(vecs[i].rst, vecs[i].req, vecs[i].busy, vecs[i].force_on);
            chk3($sformatf("vec%0d", i), vecs[i].exp_e, vecs[i].exp_ack, vecs[i].exp_state);
            check($sformatf("vec%0d.TE", i), {7'd0, TE}, {7'd0, vecs[i].exp_te});
        end

        // TE is combinational: follows SCAN_EN without a clock edge
        SCAN_EN = 1'b0;
        #1;
        check("te_comb_lo", {7'd0, TE}, 8'd0);
        SCAN_EN = 1'b1;
        #1;
        check("te_comb_hi", {7'd0, TE}, 8'd1);
        SCAN_EN = 1'b0;

        // Drain timeout with a BUSY pulse at k+8, then a full timeout
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("drn.off", 1'b0, 4'h0, 2'd0);
        go_on("drn", 4'h1);
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("drn.k", 1'b1, 4'h0, 2'd3);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 4'h0, 4'h0, 1'b0);
            chk3($sformatf("drn.k+%0d", i), 1'b1, 4'h0, 2'd3);
        end
        cyc(1'b0, 4'h0, 4'h4, 1'b0);
        chk3("drn.busy", 1'b1, 4'h0, 2'd2);
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("drn2.k", 1'b1, 4'h0, 2'd3);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 4'h0, 4'h0, 1'b0);
            chk3($sformatf("drn2.k+%0d", i), 1'b1, 4'h0, 2'd3);
        end
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("drn2.off", 1'b0, 4'h0, 2'd0);

        // Request arriving exactly on the count==0 DRAIN cycle
        go_on("race", 4'h1);
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("race.k", 1'b1, 4'h0, 2'd3);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 4'h0, 4'h0, 1'b0);
        end
        chk3("race.k+15", 1'b1, 4'h0, 2'd3);
        cyc(1'b0, 4'h2, 4'h0, 1'b0);
        chk3("race.win", 1'b1, 4'h2, 2'd2);
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("race.drop", 1'b1, 4'h0, 2'd3);
        for (int i = 1; i < 17; i++) begin
            cyc(1'b0, 4'h0, 4'h0, 1'b0);
        end
        chk3("race.off", 1'b0, 4'h0, 2'd0);

        // One-cycle REQ pulse in OFF: wake completes, no ACK, then drains
        cyc(1'b0, 4'h1, 4'h0, 1'b0);
        chk3("abort.w1", 1'b1, 4'h0, 2'd1);
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("abort.w2", 1'b1, 4'h0, 2'd1);
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("abort.on", 1'b1, 4'h0, 2'd2);
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("abort.k", 1'b1, 4'h0, 2'd3);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 4'h0, 4'h0, 1'b0);
        end
        chk3("abort.k+15", 1'b1, 4'h0, 2'd3);
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("abort.off", 1'b0, 4'h0, 2'd0);

        // Reset while ON with ACK=0110, REQ held through release
        go_on("rst", 4'h6);
        cyc(1'b1, 4'h6, 4'h0, 1'b0);
        chk3("rst.in", 1'b0, 4'h0, 2'd0);
        cyc(1'b0, 4'h6, 4'h0, 1'b0);
        chk3("rst.w1", 1'b1, 4'h0, 2'd1);
        cyc(1'b0, 4'h6, 4'h0, 1'b0);
        chk3("rst.w2", 1'b1, 4'h0, 2'd1);
        cyc(1'b0, 4'h6, 4'h0, 1'b0);
        chk3("rst.on", 1'b1, 4'h6, 2'd2);
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        chk3("rst.rel", 1'b1, 4'h0, 2'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
